// File: rtl/fp_input_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// fp_input_arbiter_pkg
// Shared constants for the FP-stage input arbiter: default packet width and
// the state encodings of the input (fill) and output (deliver) FSMs.
// ----------------------------------------------------------------------------
package fp_input_arbiter_pkg;

   localparam int unsigned FP_PACKET_SIZE = 62;

   // Input FSM: waiting for a grant / holding a producer acknowledge
   localparam logic       FPA_IN_IDLE  = 1'b0;
   localparam logic       FPA_IN_ACK   = 1'b1;

   // Output FSM: idle / Send_out raised / waiting for Ack_in to release
   localparam logic [1:0] FPA_OUT_IDLE = 2'd0;
   localparam logic [1:0] FPA_OUT_WAIT = 2'd1;
   localparam logic [1:0] FPA_OUT_REL  = 2'd2;

endpackage

// File: rtl/fp_rr_pick.sv
// ----------------------------------------------------------------------------
// fp_rr_pick
// Combinational round-robin picker. Searches i_last+1, i_last+2, ... modulo
// N_REQ and returns the first requesting index.
//   i_req   : request vector, bit i = requester i
//   i_last  : index granted most recently
//   o_valid : at least one request present
//   o_idx   : winning index (0 when o_valid=0)
// ----------------------------------------------------------------------------
module fp_rr_pick #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned ID_W  = 1
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_last,
   output logic             o_valid,
   output logic [ID_W-1:0]  o_idx
);

   always_comb begin
      int unsigned cand;
      o_valid = 1'b0;
      o_idx   = '0;
      cand    = 0;
      // k = N_REQ wraps back to i_last itself, so it has lowest priority
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = (32'(i_last) + k) % N_REQ;
         if (!o_valid && i_req[cand]) begin
            o_valid = 1'b1;
            o_idx   = ID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/fp_input_arbiter.sv
// ----------------------------------------------------------------------------
// fp_input_arbiter
// N-way round-robin arbiter merging producer packet streams into the FP stage
// input through a one-entry buffer. Both sides use a Send/Ack four-phase
// handshake.
//   CP, MR     : clock, synchronous active-high reset
//   HOLD       : blocks new grants (transfers in progress complete)
//   Send_in    : per-producer request      Ack_out  : per-producer acknowledge
//   PACKET_IN  : producer i at [i*PKT_W +: PKT_W]
//   Send_out   : request to FP             Ack_in   : acknowledge from FP
//   PACKET_OUT : buffered packet           GRANT_ID : producer owning buffer
// ----------------------------------------------------------------------------
module fp_input_arbiter
   import fp_input_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned PKT_W = FP_PACKET_SIZE,
   parameter int unsigned ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
   input  logic                   CP,
   input  logic                   MR,
   input  logic                   HOLD,
   input  logic [N_REQ-1:0]       Send_in,
   input  logic [N_REQ*PKT_W-1:0] PACKET_IN,
   output logic [N_REQ-1:0]       Ack_out,
   output logic                   Send_out,
   input  logic                   Ack_in,
   output logic [PKT_W-1:0]       PACKET_OUT,
   output logic [ID_W-1:0]        GRANT_ID
);

   logic             r_in_st,  w_in_st_nxt;
   logic [1:0]       r_out_st, w_out_st_nxt;
   logic             r_full,   w_full_nxt;
   logic [PKT_W-1:0] r_buf,    w_buf_nxt;
   logic [ID_W-1:0]  r_gid,    w_gid_nxt;
   logic [ID_W-1:0]  r_last,   w_last_nxt;
   logic [N_REQ-1:0] r_ack,    w_ack_nxt;
   logic             r_send,   w_send_nxt;
   logic             w_fill, w_clear;
   logic             w_pick_valid;
   logic [ID_W-1:0]  w_pick_idx;

   fp_rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .i_req   (Send_in),
      .i_last  (r_last),
      .o_valid (w_pick_valid),
      .o_idx   (w_pick_idx)
   );

   // Input FSM: grant only from the registered full flag, so a clear and a
   // fill can never land on the same edge.
   always_comb begin
      w_in_st_nxt = r_in_st;
      w_ack_nxt   = r_ack;
      w_buf_nxt   = r_buf;
      w_gid_nxt   = r_gid;
      w_last_nxt  = r_last;
      w_fill      = 1'b0;
      case (r_in_st)
         FPA_IN_IDLE: begin
            if (!r_full && !HOLD && w_pick_valid) begin
               w_fill                = 1'b1;
               w_buf_nxt             = PACKET_IN[32'(w_pick_idx)*PKT_W +: PKT_W];
               w_gid_nxt             = w_pick_idx;
               w_last_nxt            = w_pick_idx;
               w_ack_nxt             = '0;
               w_ack_nxt[w_pick_idx] = 1'b1;
               w_in_st_nxt           = FPA_IN_ACK;
            end
         end
         FPA_IN_ACK: begin
            // r_gid cannot change here: the next fill needs IN_IDLE
            if (!Send_in[r_gid]) begin
               w_ack_nxt   = '0;
               w_in_st_nxt = FPA_IN_IDLE;
            end
         end
         default: begin
            w_ack_nxt   = '0;
            w_in_st_nxt = FPA_IN_IDLE;
         end
      endcase
   end

   // Output FSM: a stale Ack_in blocks a new Send_out
   always_comb begin
      w_out_st_nxt = r_out_st;
      w_send_nxt   = r_send;
      w_clear      = 1'b0;
      case (r_out_st)
         FPA_OUT_IDLE: begin
            if (r_full && !Ack_in) begin
               w_send_nxt   = 1'b1;
               w_out_st_nxt = FPA_OUT_WAIT;
            end
         end
         FPA_OUT_WAIT: begin
            if (Ack_in) begin
               w_send_nxt   = 1'b0;
               w_clear      = 1'b1;
               w_out_st_nxt = FPA_OUT_REL;
            end
         end
         FPA_OUT_REL: begin
            if (!Ack_in) w_out_st_nxt = FPA_OUT_IDLE;
         end
         default: begin
            w_send_nxt   = 1'b0;
            w_out_st_nxt = FPA_OUT_IDLE;
         end
      endcase
   end

   always_comb begin
      w_full_nxt = r_full;
      if (w_fill)       w_full_nxt = 1'b1;
      else if (w_clear) w_full_nxt = 1'b0;
   end

   always_ff @(posedge CP) begin
      if (MR) begin
         r_in_st  <= FPA_IN_IDLE;
         r_out_st <= FPA_OUT_IDLE;
         r_full   <= 1'b0;
         r_buf    <= '0;
         r_gid    <= '0;
         r_last   <= ID_W'(N_REQ - 1);
         r_ack    <= '0;
         r_send   <= 1'b0;
      end else begin
         r_in_st  <= w_in_st_nxt;
         r_out_st <= w_out_st_nxt;
         r_full   <= w_full_nxt;
         r_buf    <= w_buf_nxt;
         r_gid    <= w_gid_nxt;
         r_last   <= w_last_nxt;
         r_ack    <= w_ack_nxt;
         r_send   <= w_send_nxt;
      end
   end

   assign Ack_out    = r_ack;
   assign Send_out   = r_send;
   assign PACKET_OUT = r_buf;
   assign GRANT_ID   = r_gid;

endmodule

// File: tb/tb_fp_input_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fp_input_arbiter
// Directed handshake scenarios followed by randomized producers/consumer
// checked against a transaction-level round-robin reference.
// ----------------------------------------------------------------------------
module tb_fp_input_arbiter;

   localparam int NR    = 2;
   localparam int PW    = 62;
   localparam int TOTAL = 24;

   logic             CP = 1'b0;
   logic             MR;
   logic             HOLD;
   logic [NR-1:0]    Send_in;
   logic [NR*PW-1:0] PACKET_IN;
   logic [NR-1:0]    Ack_out;
   logic             Send_out;
   logic             Ack_in;
   logic [PW-1:0]    PACKET_OUT;
   logic [0:0]       GRANT_ID;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 CP = ~CP;

   fp_input_arbiter #(
      .N_REQ (NR),
      .PKT_W (PW),
      .ID_W  (1)
   ) dut (
      .CP         (CP),
      .MR         (MR),
      .HOLD       (HOLD),
      .Send_in    (Send_in),
      .PACKET_IN  (PACKET_IN),
      .Ack_out    (Ack_out),
      .Send_out   (Send_out),
      .Ack_in     (Ack_in),
      .PACKET_OUT (PACKET_OUT),
      .GRANT_ID   (GRANT_ID)
   );

   task automatic step();
      @(posedge CP);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_pkt(input int i, input logic [PW-1:0] p);
      PACKET_IN[i*PW +: PW] = p;
   endtask

   // Spec rule: first requester after the last winner, wrapping around
   function automatic int rr_model(input logic [NR-1:0] req, input int last);
      for (int k = 1; k <= NR; k++) begin
         if (req[(last + k) % NR]) return (last + k) % NR;
      end
      return -1;
   endfunction

   logic [PW-1:0] P0 = 62'h0AAA_0000_1234_5678;
   logic [PW-1:0] P1 = 62'h1555_0000_8765_4321;

   initial begin
      logic [NR-1:0] ack, prev_ack, rose, req_prev, exp_rose;
      logic          so, prev_so;
      logic [PW-1:0] cur [NR];
      logic [PW-1:0] exp_q [$];
      logic [PW-1:0] held;
      logic [63:0]   rnd;
      int            pend [NR];
      int            dly [NR];
      int            cdly, model_last, delivered, grants, cyc, w;

      // ---------------- reset with both producers requesting
      MR = 1'b1; HOLD = 1'b0; Ack_in = 1'b0; Send_in = 2'b11;
      set_pkt(0, P0); set_pkt(1, P1);
      step(); step();
      chk("rst_ack", Ack_out, 0);
      chk("rst_send", Send_out, 0);
      chk("rst_pkt", PACKET_OUT, 0);
      chk("rst_gid", GRANT_ID, 0);
      MR = 1'b0;
      step();
      chk("first_ack", Ack_out, 2'b01);
      chk("first_gid", GRANT_ID, 0);
      chk("first_pkt", PACKET_OUT, P0);
      chk("first_send_lat", Send_out, 0);
      step();
      chk("first_send", Send_out, 1);
      Send_in = 2'b10;
      step();
      chk("p0_release", Ack_out, 2'b00);

      // ---------------- backpressure: buffer stays put, producer 1 waits
      for (int i = 0; i < 20; i++) begin
         chk("bp_send", Send_out, 1);
         chk("bp_pkt", PACKET_OUT, P0);
         chk("bp_ack", Ack_out, 2'b00);
         step();
      end
      Ack_in = 1'b1;
      step();
      chk("bp_send_drop", Send_out, 0);
      step();
      chk("p1_ack", Ack_out, 2'b10);
      chk("p1_gid", GRANT_ID, 1);
      chk("p1_pkt", PACKET_OUT, P1);
      chk("p1_rel_blocks", Send_out, 0);
      Ack_in = 1'b0; Send_in = 2'b00;
      step();
      chk("p1_release", Ack_out, 2'b00);
      chk("p1_send_lat", Send_out, 0);
      step();
      chk("p1_send", Send_out, 1);
      Ack_in = 1'b1;
      step();
      chk("p1_send_drop", Send_out, 0);
      Ack_in = 1'b0;
      step();

      // ---------------- single transfer latency from producer 1
      Send_in = 2'b10;
      step();
      chk("lat_ack", Ack_out, 2'b10);
      chk("lat_send0", Send_out, 0);
      step();
      chk("lat_send1", Send_out, 1);
      Send_in = 2'b00; Ack_in = 1'b1;
      step();
      chk("lat_send_drop", Send_out, 0);
      chk("lat_ack_drop", Ack_out, 2'b00);
      Ack_in = 1'b0;
      step();

      // ---------------- HOLD, then a stale Ack_in blocking Send_out
      HOLD = 1'b1; Send_in = 2'b01; Ack_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("hold_ack", Ack_out, 2'b00);
         chk("hold_send", Send_out, 0);
      end
      HOLD = 1'b0;
      step();
      chk("hold_rel_ack", Ack_out, 2'b01);
      chk("hold_rel_gid", GRANT_ID, 0);
      Send_in = 2'b00;
      step();
      chk("stale_blk0", Send_out, 0);
      step();
      chk("stale_blk1", Send_out, 0);
      Ack_in = 1'b0;
      step();
      chk("stale_send", Send_out, 1);
      Ack_in = 1'b1;
      step();
      chk("stale_send_drop", Send_out, 0);
      Ack_in = 1'b0;
      step();

      // ---------------- fairness from reset, zero-delay partners
      MR = 1'b1; step(); MR = 1'b0;
      Send_in = 2'b11; prev_ack = '0; grants = 0; cyc = 0;
      while (grants < 8 && cyc < 200) begin
         step();
         cyc++;
         ack = Ack_out;
         chk("fair_no_overlap", ack == 2'b11, 0);
         rose = ack & ~prev_ack;
         if (rose != 0) begin
            chk("fair_gid", GRANT_ID, grants % 2);
            grants++;
         end
         for (int i = 0; i < NR; i++) begin
            if (Send_in[i] && ack[i])        Send_in[i] = 1'b0;
            else if (!Send_in[i] && !ack[i]) Send_in[i] = 1'b1;
         end
         Ack_in = Send_out;
         prev_ack = ack;
      end
      chk("fair_count", grants, 8);
      Send_in = 2'b00;
      for (int i = 0; i < 10; i++) begin
         step();
         Ack_in = Send_out;
      end

      // ---------------- reset mid-transfer restores pointer to producer 0 first
      MR = 1'b1; Ack_in = 1'b0; step(); MR = 1'b0; step();
      Send_in = 2'b01;
      step();
      chk("mid_ack", Ack_out, 2'b01);
      Send_in = 2'b00;
      step();
      chk("mid_send", Send_out, 1);
      MR = 1'b1; Send_in = 2'b11;
      step();
      chk("mid_rst_send", Send_out, 0);
      chk("mid_rst_ack", Ack_out, 2'b00);
      chk("mid_rst_pkt", PACKET_OUT, 0);
      MR = 1'b0;
      step();
      chk("mid_restart_ack", Ack_out, 2'b01);
      chk("mid_restart_gid", GRANT_ID, 0);
      MR = 1'b1; Send_in = 2'b00; step(); MR = 1'b0; step();

      // ---------------- randomized producers and consumer
      model_last = NR - 1;
      for (int i = 0; i < NR; i++) begin
         pend[i] = TOTAL / NR; dly[i] = $urandom_range(0, 3); cur[i] = '0;
      end
      cdly = 0; delivered = 0; cyc = 0; prev_ack = '0; prev_so = 1'b0; held = '0;
      while (delivered < TOTAL && cyc < 3000) begin
         req_prev = Send_in;
         step();
         cyc++;
         ack = Ack_out;
         so  = Send_out;
         chk("rnd_ack_onehot", $countones(ack) <= 1, 1);
         rose = ack & ~prev_ack;
         if (rose != 0) begin
            w = rr_model(req_prev, model_last);
            exp_rose = (w < 0) ? '0 : NR'(1 << w);
            chk("rnd_rr_winner", rose, exp_rose);
            if (w >= 0) begin
               chk("rnd_gid", GRANT_ID, w);
               model_last = w;
               exp_q.push_back(cur[w]);
            end
         end
         if (so && !prev_so) begin
            chk("rnd_deliver_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               held = exp_q.pop_front();
               chk("rnd_deliver", PACKET_OUT, held);
            end
            delivered++;
         end else if (so) begin
            chk("rnd_stable", PACKET_OUT, held);
         end
         for (int i = 0; i < NR; i++) begin
            if (Send_in[i] && ack[i]) begin
               Send_in[i] = 1'b0;
               pend[i]--;
               dly[i] = $urandom_range(0, 3);
            end else if (!Send_in[i] && !ack[i] && pend[i] > 0) begin
               if (dly[i] > 0) dly[i]--;
               else begin
                  rnd = {$urandom(), $urandom()};
                  cur[i] = rnd[PW-1:0];
                  set_pkt(i, cur[i]);
                  Send_in[i] = 1'b1;
               end
            end
         end
         if (so && !Ack_in) begin
            if (cdly > 0) cdly--;
            else begin Ack_in = 1'b1; cdly = $urandom_range(0, 3); end
         end else if (!so && Ack_in) begin
            if (cdly > 0) cdly--;
            else begin Ack_in = 1'b0; cdly = $urandom_range(0, 3); end
         end
         HOLD = ($urandom_range(0, 7) == 0);
         prev_ack = ack;
         prev_so  = so;
      end
      chk("rnd_delivered", delivered, TOTAL);
      chk("rnd_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
